// File: rtl/vic_fetch_capture_pkg.sv
// Shared VIC sequencer cycle-type encodings and capture constants.
package vic_fetch_capture_pkg;

  // Sequencer cycle types, numbered as in the legacy common.vh defines.
  typedef enum logic [3:0] {
    VIC_LP   = 4'd0,
    VIC_LPI2 = 4'd1,
    VIC_LS2  = 4'd2,
    VIC_LR   = 4'd3,
    VIC_LG   = 4'd4,
    VIC_HS1  = 4'd5,
    VIC_HPI1 = 4'd6,
    VIC_HPI2 = 4'd7,
    VIC_HS3  = 4'd8,
    VIC_HRI  = 4'd9,
    VIC_HRC  = 4'd10,
    VIC_HGC  = 4'd11,
    VIC_HGI  = 4'd12,
    VIC_HI   = 4'd13,
    VIC_LI   = 4'd14,
    VIC_HRX  = 4'd15
  } cycle_type_t;

  // Char byte substituted when the CPU holds the bus during a c-access.
  localparam logic [7:0] CHAR_FF = 8'hFF;

  function automatic logic is_c_access(input cycle_type_t t);
    return (t == VIC_HRC) || (t == VIC_HGC);
  endfunction

  function automatic logic is_cached_read(input cycle_type_t t);
    return (t == VIC_HRX) || (t == VIC_HGI);
  endfunction

endpackage

// File: rtl/vic_fetch_capture_line_buf.sv
// Character line buffer: single-port RAM addressed by the column counter,
// with runtime column clamping and a sticky wrap (overrun) flag.
module vic_line_buf
  import vic_fetch_capture_pkg::*;
#(
  parameter int MAX_COLS = 40,
  parameter int DATA_W   = 12
) (
  input  logic              clk_dot4x,
  input  logic              rst,
  input  logic              access_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              line_start_i,
  input  logic [7:0]        num_cols_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              overrun_o
);

  localparam int IDX_W = $clog2(MAX_COLS);
  localparam logic [7:0] MAX_COLS_B = 8'(MAX_COLS);

  logic [DATA_W-1:0] mem_q [MAX_COLS];
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        eff_cols;
  logic              at_end;

  // Clamp column count and step the counter; line_start overrides any access.
  always_comb begin
    eff_cols = ((num_cols_i == 8'd0) || (num_cols_i > MAX_COLS_B)) ? MAX_COLS_B : num_cols_i;
    // >= rather than == so a mid-line shrink below the counter still wraps
    at_end   = (8'(cnt_q) >= (eff_cols - 8'd1));
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    if (access_i) begin
      if (at_end) begin
        cnt_d = '0;
        ovr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (line_start_i) begin
      cnt_d = '0;
      ovr_d = 1'b0;
    end
  end

  // Counter and overrun registers.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  // Buffer RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk_dot4x) begin
    if (wr_en_i) mem_q[cnt_q] <= wdata_i;
  end

  assign rdata_o   = mem_q[cnt_q];
  assign overrun_o = ovr_q;

endmodule

// File: rtl/vic_fetch_capture.sv
// VIC data-bus capture: latches c-, g- and p-access data from dbi on the
// data-valid strobe and feeds the pixel and sprite pipelines.
module vic_fetch_capture
  import vic_fetch_capture_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int MAX_COLS    = 40,
  parameter int DATA_W      = 12,
  parameter int BLANK_CYCLE = 55,
  parameter int SPR_IDX_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                     clk_dot4x,
  input  logic                     rst,
  input  logic                     phi_phase_start_dav,
  input  logic                     phi_phase_start_0,
  input  logic                     clk_phi,
  input  logic [3:0]               cycle_type,
  input  logic [6:0]               cycle_num,
  input  logic [DATA_W-1:0]        dbi,
  input  logic                     aec,
  input  logic                     idle,
  input  logic [SPR_IDX_W-1:0]     sprite_cnt,
  input  logic [NUM_SPRITES-1:0]   sprite_dma,
  input  logic                     line_start,
  input  logic [7:0]               num_cols,
  output logic [NUM_SPRITES*8-1:0] sprite_ptr_o,
  output logic [NUM_SPRITES-1:0]   sprite_ptr_valid,
  output logic [7:0]               pixels_read,
  output logic [DATA_W-1:0]        char_read,
  output logic [DATA_W-1:0]        char_next,
  output logic                     cbuf_overrun
);

  cycle_type_t ct;
  logic c_acc, cached_rd, lg_cap, lp_cap, blank;
  logic [DATA_W-1:0] c_val, buf_rdata;

  logic [DATA_W-1:0]                char_next_q, char_next_d;
  logic [DATA_W-1:0]                char_read_q, char_read_d;
  logic [7:0]                       pixels_q, pixels_d;
  logic [NUM_SPRITES-1:0][7:0]      ptr_q, ptr_d;
  logic [NUM_SPRITES-1:0]           valid_q, valid_d;

  assign ct        = cycle_type_t'(cycle_type);
  assign c_acc     = phi_phase_start_dav && is_c_access(ct);
  assign cached_rd = phi_phase_start_dav && is_cached_read(ct);
  assign lg_cap    = phi_phase_start_dav && (ct == VIC_LG) && !aec;
  assign lp_cap    = phi_phase_start_dav && (ct == VIC_LP) && !aec &&
                     (int'(sprite_cnt) < NUM_SPRITES);
  assign blank     = clk_phi && (cycle_num == 7'(BLANK_CYCLE)) && phi_phase_start_0;
  assign c_val     = aec ? {dbi[DATA_W-1:8], CHAR_FF} : dbi;

  vic_line_buf #(
    .MAX_COLS (MAX_COLS),
    .DATA_W   (DATA_W)
  ) u_line_buf (
    .clk_dot4x    (clk_dot4x),
    .rst          (rst),
    .access_i     (c_acc || cached_rd),
    .wr_en_i      (c_acc),
    .wdata_i      (c_val),
    .line_start_i (line_start),
    .num_cols_i   (num_cols),
    .rdata_o      (buf_rdata),
    .overrun_o    (cbuf_overrun)
  );

  // Next-state selection for all captured outputs.
  always_comb begin
    char_next_d = char_next_q;
    char_read_d = char_read_q;
    pixels_d    = pixels_q;
    ptr_d       = ptr_q;
    valid_d     = valid_q;
    if (c_acc)          char_next_d = c_val;
    else if (cached_rd) char_next_d = buf_rdata;
    if (lg_cap) begin
      pixels_d    = dbi[7:0];
      char_read_d = idle ? '0 : char_next_q;
    end
    if (blank) pixels_d = '0;
    if (lp_cap) begin
      if (sprite_dma[sprite_cnt]) begin
        ptr_d[sprite_cnt]   = dbi[7:0];
        valid_d[sprite_cnt] = 1'b1;
      end else begin
        ptr_d[sprite_cnt]   = 8'hFF;
      end
    end
    if (line_start) valid_d = '0;
  end

  // Output registers.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      char_next_q <= '0;
      char_read_q <= '0;
      pixels_q    <= '0;
      ptr_q       <= '0;
      valid_q     <= '0;
    end else begin
      char_next_q <= char_next_d;
      char_read_q <= char_read_d;
      pixels_q    <= pixels_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
    end
  end

  // Flatten pointers with sprite 0 in the most significant byte.
  always_comb begin
    sprite_ptr_o = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++)
      sprite_ptr_o[(NUM_SPRITES-1-i)*8 +: 8] = ptr_q[i];
  end

  assign char_next        = char_next_q;
  assign char_read        = char_read_q;
  assign pixels_read      = pixels_q;
  assign sprite_ptr_valid = valid_q;

endmodule

// File: tb/tb_vic_fetch_capture.sv
// Scoreboard bench for vic_fetch_capture (16 sprites, 80-column buffer).
module tb_vic_fetch_capture;
  import vic_fetch_capture_pkg::*;

  localparam int NS = 16;
  localparam int MC = 80;
  localparam int DW = 12;

  logic           clk_dot4x = 1'b0;
  logic           rst = 1'b0;
  logic           phi_phase_start_dav = 1'b0;
  logic           phi_phase_start_0 = 1'b0;
  logic           clk_phi = 1'b0;
  logic [3:0]     cycle_type = 4'd13;
  logic [6:0]     cycle_num = 7'd0;
  logic [DW-1:0]  dbi = '0;
  logic           aec = 1'b0;
  logic           idle = 1'b0;
  logic [3:0]     sprite_cnt = '0;
  logic [NS-1:0]  sprite_dma = '0;
  logic           line_start = 1'b0;
  logic [7:0]     num_cols = 8'd40;
  logic [NS*8-1:0] sprite_ptr_o;
  logic [NS-1:0]  sprite_ptr_valid;
  logic [7:0]     pixels_read;
  logic [DW-1:0]  char_read;
  logic [DW-1:0]  char_next;
  logic           cbuf_overrun;

  always #5 clk_dot4x = ~clk_dot4x;

  vic_fetch_capture #(
    .NUM_SPRITES (NS),
    .MAX_COLS    (MC),
    .DATA_W      (DW),
    .BLANK_CYCLE (55)
  ) dut (
    .clk_dot4x           (clk_dot4x),
    .rst                 (rst),
    .phi_phase_start_dav (phi_phase_start_dav),
    .phi_phase_start_0   (phi_phase_start_0),
    .clk_phi             (clk_phi),
    .cycle_type          (cycle_type),
    .cycle_num           (cycle_num),
    .dbi                 (dbi),
    .aec                 (aec),
    .idle                (idle),
    .sprite_cnt          (sprite_cnt),
    .sprite_dma          (sprite_dma),
    .line_start          (line_start),
    .num_cols            (num_cols),
    .sprite_ptr_o        (sprite_ptr_o),
    .sprite_ptr_valid    (sprite_ptr_valid),
    .pixels_read         (pixels_read),
    .char_read           (char_read),
    .char_next           (char_next),
    .cbuf_overrun        (cbuf_overrun)
  );

  typedef struct {
    string        tag;
    int           sel;
    logic [127:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state.
  logic [DW-1:0] mbuf [128];
  int            m_cnt = 0;
  logic          m_ovr = 1'b0;
  logic [DW-1:0] m_cn = '0, m_cr = '0;
  logic [7:0]    m_pix = '0;
  logic [7:0]    m_ptr [NS];
  logic [NS-1:0] m_val = '0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] observe(input int sel);
    case (sel)
      0:       return 128'(char_next);
      1:       return 128'(char_read);
      2:       return 128'(pixels_read);
      3:       return 128'(sprite_ptr_o);
      4:       return 128'(sprite_ptr_valid);
      default: return 128'(cbuf_overrun);
    endcase
  endfunction

  // Advance the model on the current inputs, queue expectations, clock, compare.
  task automatic tick(input string tag);
    int eff;
    logic acc;
    logic [DW-1:0] v, n_cn, n_cr;
    logic [7:0] n_pix;
    logic [127:0] fl;
    exp_t e;
    eff = ((num_cols == 8'd0) || (int'(num_cols) > MC)) ? MC : int'(num_cols);
    if (rst) begin
      m_cnt = 0; m_ovr = 1'b0; m_cn = '0; m_cr = '0; m_pix = '0; m_val = '0;
      for (int i = 0; i < NS; i++) m_ptr[i] = 8'h00;
    end else begin
      acc = 1'b0; n_cn = m_cn; n_cr = m_cr; n_pix = m_pix;
      if (phi_phase_start_dav) begin
        case (cycle_type)
          VIC_HRC, VIC_HGC: begin
            v = aec ? {dbi[11:8], 8'hFF} : dbi;
            n_cn = v; mbuf[m_cnt] = v; acc = 1'b1;
          end
          VIC_HRX, VIC_HGI: begin n_cn = mbuf[m_cnt]; acc = 1'b1; end
          VIC_LG: if (!aec) begin n_pix = dbi[7:0]; n_cr = idle ? '0 : m_cn; end
          VIC_LP: if (!aec) begin
            if (sprite_dma[sprite_cnt]) begin m_ptr[sprite_cnt] = dbi[7:0]; m_val[sprite_cnt] = 1'b1; end
            else m_ptr[sprite_cnt] = 8'hFF;
          end
          default: ;
        endcase
      end
      if (clk_phi && cycle_num == 7'd55 && phi_phase_start_0) n_pix = '0;
      if (acc) begin
        if (m_cnt >= eff - 1) begin m_cnt = 0; m_ovr = 1'b1; end
        else m_cnt++;
      end
      if (line_start) begin m_cnt = 0; m_ovr = 1'b0; m_val = '0; end
      m_cn = n_cn; m_cr = n_cr; m_pix = n_pix;
    end
    fl = '0;
    for (int i = 0; i < NS; i++) fl[(NS-1-i)*8 +: 8] = m_ptr[i];
    sb.push_back('{tag: {tag, ".char_next"}, sel: 0, exp: 128'(m_cn)});
    sb.push_back('{tag: {tag, ".char_read"}, sel: 1, exp: 128'(m_cr)});
    sb.push_back('{tag: {tag, ".pixels"},    sel: 2, exp: 128'(m_pix)});
    sb.push_back('{tag: {tag, ".ptr"},       sel: 3, exp: fl});
    sb.push_back('{tag: {tag, ".valid"},     sel: 4, exp: 128'(m_val)});
    sb.push_back('{tag: {tag, ".overrun"},   sel: 5, exp: 128'(m_ovr)});
    @(posedge clk_dot4x);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk_eq(e.tag, observe(e.sel), e.exp);
    end
    rst = 1'b0; phi_phase_start_dav = 1'b0; line_start = 1'b0; phi_phase_start_0 = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] ct, input logic [DW-1:0] d, input logic a, input string tag);
    cycle_type = ct; dbi = d; aec = a; phi_phase_start_dav = 1'b1;
    tick(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_dot4x);
    rst = 1'b1; tick("rst");
    tick("idle");

    // 40 columns: fill, wrap, overrun, clear
    num_cols = 8'd40;
    for (int i = 0; i < 40; i++) begin
      strobe(VIC_HGC, 12'h5A0 + 12'(i), 1'b0, "hgc40");
      tick("gap");
    end
    chk_eq("fill40_last", 128'(char_next), 128'(12'h5C7));
    chk_eq("fill40_ovr", 128'(cbuf_overrun), 128'(1'b1));
    strobe(VIC_HGI, 12'h000, 1'b0, "wrap_rd0");
    chk_eq("wrap_rd0_val", 128'(char_next), 128'(12'h5A0));
    line_start = 1'b1; tick("ls_clr");
    chk_eq("ls_clr_ovr", 128'(cbuf_overrun), 128'(1'b0));

    // CPU-owned c-access substitutes 0xFF char; cached read returns it
    strobe(VIC_HGC, 12'hA33, 1'b1, "hgc_aec");
    chk_eq("hgc_aec_val", 128'(char_next), 128'(12'hAFF));
    line_start = 1'b1; tick("ls");
    strobe(VIC_HGI, 12'h000, 1'b0, "hgi_aec");
    chk_eq("hgi_aec_val", 128'(char_next), 128'(12'hAFF));

    // Non-capturing cycle type
    strobe(VIC_HI, 12'h777, 1'b0, "hi_nop");

    // line_start coinciding with the wrapping access
    num_cols = 8'd3; line_start = 1'b1; tick("ls3");
    strobe(VIC_HGC, 12'h111, 1'b0, "c3a");
    strobe(VIC_HGC, 12'h222, 1'b0, "c3b");
    line_start = 1'b1;
    strobe(VIC_HGC, 12'h333, 1'b0, "c3_ls");
    chk_eq("c3_ls_ovr", 128'(cbuf_overrun), 128'(1'b0));
    strobe(VIC_HGI, 12'h000, 1'b0, "c3_rd");
    chk_eq("c3_rd_val", 128'(char_next), 128'(12'h111));

    // Mid-line shrink below the counter wraps on the next access
    num_cols = 8'd40; line_start = 1'b1; tick("ls40");
    for (int i = 0; i < 10; i++) strobe(VIC_HGC, 12'h300 + 12'(i), 1'b0, "mid");
    num_cols = 8'd5;
    strobe(VIC_HGC, 12'h3FF, 1'b0, "shrink");
    chk_eq("shrink_ovr", 128'(cbuf_overrun), 128'(1'b1));
    strobe(VIC_HGI, 12'h000, 1'b0, "shrink_rd");
    chk_eq("shrink_rd_val", 128'(char_next), 128'(12'h300));

    // Full 80 columns: write, then cached reads with num_cols=0 (clamped)
    num_cols = 8'd80; line_start = 1'b1; tick("ls80");
    for (int i = 0; i < 80; i++) begin
      strobe(VIC_HRC, 12'(i * 37 + 12'h100), 1'b0, "hrc80");
      if (i == 78) chk_eq("hrc79_noovr", 128'(cbuf_overrun), 128'(1'b0));
    end
    chk_eq("hrc80_ovr", 128'(cbuf_overrun), 128'(1'b1));
    num_cols = 8'd0; line_start = 1'b1; tick("ls80b");
    for (int i = 0; i < 80; i++) begin
      strobe(VIC_HRX, 12'h000, 1'b0, "hrx80");
      chk_eq("hrx80_val", 128'(char_next), 128'(12'(i * 37 + 12'h100)));
    end

    // g-access, idle, blanking priority
    idle = 1'b1;
    strobe(VIC_LG, 12'h0C3, 1'b0, "lg_idle");
    chk_eq("lg_idle_pix", 128'(pixels_read), 128'(8'hC3));
    chk_eq("lg_idle_cr", 128'(char_read), 128'(12'h000));
    idle = 1'b0;
    strobe(VIC_LG, 12'h03C, 1'b0, "lg");
    strobe(VIC_LG, 12'h0AA, 1'b1, "lg_aec");
    clk_phi = 1'b1; cycle_num = 7'd55; phi_phase_start_0 = 1'b1;
    strobe(VIC_LG, 12'h0C3, 1'b0, "lg_blank");
    chk_eq("lg_blank_pix", 128'(pixels_read), 128'(8'h00));
    strobe(VIC_LG, 12'h05A, 1'b0, "lg2");
    cycle_num = 7'd54; phi_phase_start_0 = 1'b1; tick("noblank54");
    cycle_num = 7'd55; phi_phase_start_0 = 1'b1; tick("blank_only");
    clk_phi = 1'b0; cycle_num = 7'd0;

    // p-access
    sprite_cnt = 4'd11; sprite_dma = 16'h0800;
    strobe(VIC_LP, 12'h07E, 1'b0, "lp11");
    chk_eq("lp11_ptr", 128'(sprite_ptr_o[39:32]), 128'(8'h7E));
    chk_eq("lp11_val", 128'(sprite_ptr_valid[11]), 128'(1'b1));
    sprite_dma = '0;
    strobe(VIC_LP, 12'h055, 1'b0, "lp11_nodma");
    chk_eq("lp11_nodma_ptr", 128'(sprite_ptr_o[39:32]), 128'(8'hFF));
    sprite_cnt = 4'd0; sprite_dma = 16'h0001;
    strobe(VIC_LP, 12'h012, 1'b1, "lp0_aec");
    strobe(VIC_LP, 12'h034, 1'b0, "lp0");
    chk_eq("lp0_msb", 128'(sprite_ptr_o[127:120]), 128'(8'h34));
    line_start = 1'b1; tick("ls_valid");

    // Reset mid-line, then first c-access lands in buf[0]
    num_cols = 8'd40; line_start = 1'b1; tick("ls_r");
    for (int i = 0; i < 20; i++) strobe(VIC_HGC, 12'h400 + 12'(i), 1'b0, "pre_rst");
    rst = 1'b1; tick("rst_mid");
    chk_eq("rst_mid_cn", 128'(char_next), 128'(12'h000));
    strobe(VIC_HGC, 12'h123, 1'b0, "post_rst");
    line_start = 1'b1; tick("ls_pr");
    strobe(VIC_HGI, 12'h000, 1'b0, "post_rst_rd");
    chk_eq("post_rst_rd_val", 128'(char_next), 128'(12'h123));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
